// File: rtl/id_ex_stage.sv
// ID/EX pipeline register feeding the RV32IM ALU: operand select, optional forwarding
// (ID_EX_FORWARD_EN) and a fixed hold on divide/remainder ops for the multicycle divider.
module id_ex_stage #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned DIV_CYCLES = 4
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_pc,
  input  logic [XLEN-1:0] in_rs1_data,
  input  logic [XLEN-1:0] in_rs2_data,
  input  logic [XLEN-1:0] in_imm,
  input  logic [4:0]      in_rs1_addr,
  input  logic [4:0]      in_rs2_addr,
  input  logic [4:0]      in_rd_addr,
  input  logic [4:0]      in_alu_select,
  input  logic            in_op1_sel,
  input  logic            in_op2_sel,
  input  logic            in_reg_write,
  input  logic            flush,
  input  logic            exmem_reg_write,
  input  logic [4:0]      exmem_rd_addr,
  input  logic [XLEN-1:0] exmem_result,
  input  logic            memwb_reg_write,
  input  logic [4:0]      memwb_rd_addr,
  input  logic [XLEN-1:0] memwb_result,
  input  logic            out_ready,
  output logic            out_valid,
  output logic [XLEN-1:0] alu_data1,
  output logic [XLEN-1:0] alu_data2,
  output logic [4:0]      alu_select,
  output logic [XLEN-1:0] out_rs2_data,
  output logic [XLEN-1:0] out_pc,
  output logic [4:0]      out_rd_addr,
  output logic            out_reg_write
);

  localparam int unsigned CntW = (DIV_CYCLES > 0) ? $clog2(DIV_CYCLES + 1) : 1;

  logic            valid_q, valid_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [XLEN-1:0] pc_q, rs1_q, rs2_q, imm_q;
  logic [4:0]      rs1_addr_q, rs2_addr_q, rd_q, sel_q;
  logic            op1_sel_q, op2_sel_q, reg_write_q;
  logic [XLEN-1:0] rs1_f, rs2_f;
  logic            load, drain, hold, in_is_div;

  assign in_is_div = in_alu_select[4] & in_alu_select[0];
  assign out_valid = valid_q && (cnt_q == '0);
  // Gated by reset so every output reads 0 while reset is asserted.
  assign in_ready  = rst_n && (!valid_q || (out_valid && out_ready));
  assign load      = in_valid && in_ready && !flush;
  assign drain     = out_valid && out_ready;
  assign hold      = valid_q && !drain && !flush;

  always_comb begin
    valid_d = valid_q;
    cnt_d   = cnt_q;
    if (flush) begin
      valid_d = 1'b0;
      cnt_d   = '0;
    end else if (load) begin
      valid_d = 1'b1;
      cnt_d   = in_is_div ? CntW'(DIV_CYCLES) : '0;
    end else if (drain) begin
      valid_d = 1'b0;
    end else if (cnt_q != '0) begin
      cnt_d = cnt_q - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      valid_q <= valid_d;
      cnt_q   <= cnt_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pc_q        <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      imm_q       <= '0;
      rs1_addr_q  <= '0;
      rs2_addr_q  <= '0;
      rd_q        <= '0;
      sel_q       <= '0;
      op1_sel_q   <= 1'b0;
      op2_sel_q   <= 1'b0;
      reg_write_q <= 1'b0;
    end else if (load) begin
      pc_q        <= in_pc;
      rs1_q       <= in_rs1_data;
      rs2_q       <= in_rs2_data;
      imm_q       <= in_imm;
      rs1_addr_q  <= in_rs1_addr;
      rs2_addr_q  <= in_rs2_addr;
      rd_q        <= in_rd_addr;
      sel_q       <= in_alu_select;
      op1_sel_q   <= in_op1_sel;
      op2_sel_q   <= in_op2_sel;
      reg_write_q <= in_reg_write;
    end else if (hold) begin
      // Capture forwarded values so they survive the producer retiring during a stall.
      rs1_q <= rs1_f;
      rs2_q <= rs2_f;
    end
  end

`ifdef ID_EX_FORWARD_EN
  assign rs1_f = (exmem_reg_write && (exmem_rd_addr != 5'd0) && (exmem_rd_addr == rs1_addr_q))
               ? exmem_result
               : (memwb_reg_write && (memwb_rd_addr != 5'd0) && (memwb_rd_addr == rs1_addr_q))
               ? memwb_result : rs1_q;
  assign rs2_f = (exmem_reg_write && (exmem_rd_addr != 5'd0) && (exmem_rd_addr == rs2_addr_q))
               ? exmem_result
               : (memwb_reg_write && (memwb_rd_addr != 5'd0) && (memwb_rd_addr == rs2_addr_q))
               ? memwb_result : rs2_q;
`else
  assign rs1_f = rs1_q;
  assign rs2_f = rs2_q;
  logic unused_fwd;
  assign unused_fwd = ^{exmem_reg_write, exmem_rd_addr, exmem_result, memwb_reg_write,
                        memwb_rd_addr, memwb_result, rs1_addr_q, rs2_addr_q};
`endif

  assign alu_data1     = op1_sel_q ? pc_q : rs1_f;
  assign alu_data2     = op2_sel_q ? imm_q : rs2_f;
  assign out_rs2_data  = rs2_f;
  assign alu_select    = sel_q;
  assign out_pc        = pc_q;
  assign out_rd_addr   = rd_q;
  assign out_reg_write = reg_write_q && out_valid;

endmodule

// File: tb/tb_id_ex_stage.sv
// Directed self-checking bench for id_ex_stage (DIV_CYCLES=4); forwarding cases run only
// when ID_EX_FORWARD_EN is defined.
module tb_id_ex_stage;

  localparam logic [4:0] SelAdd = 5'b00000;
  localparam logic [4:0] SelMul = 5'b00001;
  localparam logic [4:0] SelXor = 5'b10000;
  localparam logic [4:0] SelDiv = 5'b10001;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid, in_ready;
  logic [31:0] in_pc, in_rs1_data, in_rs2_data, in_imm;
  logic [4:0]  in_rs1_addr, in_rs2_addr, in_rd_addr, in_alu_select;
  logic        in_op1_sel, in_op2_sel, in_reg_write, flush;
  logic        exmem_reg_write, memwb_reg_write;
  logic [4:0]  exmem_rd_addr, memwb_rd_addr;
  logic [31:0] exmem_result, memwb_result;
  logic        out_ready, out_valid, out_reg_write;
  logic [31:0] alu_data1, alu_data2, out_rs2_data, out_pc;
  logic [4:0]  alu_select, out_rd_addr;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  id_ex_stage #(.XLEN(32), .DIV_CYCLES(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_pc(in_pc), .in_rs1_data(in_rs1_data), .in_rs2_data(in_rs2_data), .in_imm(in_imm),
    .in_rs1_addr(in_rs1_addr), .in_rs2_addr(in_rs2_addr), .in_rd_addr(in_rd_addr),
    .in_alu_select(in_alu_select), .in_op1_sel(in_op1_sel), .in_op2_sel(in_op2_sel),
    .in_reg_write(in_reg_write), .flush(flush),
    .exmem_reg_write(exmem_reg_write), .exmem_rd_addr(exmem_rd_addr),
    .exmem_result(exmem_result),
    .memwb_reg_write(memwb_reg_write), .memwb_rd_addr(memwb_rd_addr),
    .memwb_result(memwb_result),
    .out_ready(out_ready), .out_valid(out_valid),
    .alu_data1(alu_data1), .alu_data2(alu_data2), .alu_select(alu_select),
    .out_rs2_data(out_rs2_data), .out_pc(out_pc), .out_rd_addr(out_rd_addr),
    .out_reg_write(out_reg_write)
  );

  typedef struct {
    logic [4:0]  sel;
    logic [31:0] pc, rs1, rs2, imm;
    logic        op1, op2;
    logic [4:0]  rd;
    logic [31:0] e1, e2;
  } vec_t;

  vec_t vecs[4];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [4:0] sel, input logic [31:0] pc, input logic [31:0] rs1,
                       input logic [31:0] rs2, input logic [31:0] imm, input logic op1,
                       input logic op2, input logic [4:0] rd, input logic [4:0] a1,
                       input logic [4:0] a2);
    in_valid      = 1'b1;
    in_alu_select = sel;
    in_pc         = pc;
    in_rs1_data   = rs1;
    in_rs2_data   = rs2;
    in_imm        = imm;
    in_op1_sel    = op1;
    in_op2_sel    = op2;
    in_rd_addr    = rd;
    in_rs1_addr   = a1;
    in_rs2_addr   = a2;
    in_reg_write  = 1'b1;
  endtask

  initial begin
    vecs[0] = '{SelAdd, 32'h0000_0040, 32'h10, 32'h20, 32'h0, 1'b0, 1'b0, 5'd3, 32'h10, 32'h20};
    vecs[1] = '{SelAdd, 32'h0000_0100, 32'h1, 32'h2, 32'h8, 1'b1, 1'b1, 5'd4, 32'h100, 32'h8};
    vecs[2] = '{SelXor, 32'h0000_0104, 32'hF0, 32'h0F, 32'h4, 1'b0, 1'b1, 5'd5, 32'hF0, 32'h4};
    vecs[3] = '{SelMul, 32'h0000_0108, 32'h3, 32'h5, 32'h0, 1'b0, 1'b0, 5'd6, 32'h3, 32'h5};

    rst_n = 1'b0; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b1;
    in_pc = '0; in_rs1_data = '0; in_rs2_data = '0; in_imm = '0;
    in_rs1_addr = '0; in_rs2_addr = '0; in_rd_addr = '0; in_alu_select = '0;
    in_op1_sel = 1'b0; in_op2_sel = 1'b0; in_reg_write = 1'b0;
    exmem_reg_write = 1'b0; exmem_rd_addr = '0; exmem_result = '0;
    memwb_reg_write = 1'b0; memwb_rd_addr = '0; memwb_result = '0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    check("reset_in_ready", 32'(in_ready), 32'd1);
    check("reset_out_valid", 32'(out_valid), 32'd0);
    check("reset_data1", alu_data1, 32'h0);

    // Back-to-back stream, including non-divide ops with select bit 4 or bit 0 set.
    for (int i = 0; i < 4; i++) begin
      drive(vecs[i].sel, vecs[i].pc, vecs[i].rs1, vecs[i].rs2, vecs[i].imm, vecs[i].op1,
            vecs[i].op2, vecs[i].rd, 5'd0, 5'd0);
      cyc();
      check($sformatf("stream%0d_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("stream%0d_sel", i), 32'(alu_select), 32'(vecs[i].sel));
      check($sformatf("stream%0d_data1", i), alu_data1, vecs[i].e1);
      check($sformatf("stream%0d_data2", i), alu_data2, vecs[i].e2);
      check($sformatf("stream%0d_pc", i), out_pc, vecs[i].pc);
      check($sformatf("stream%0d_rd", i), 32'(out_rd_addr), 32'(vecs[i].rd));
      check($sformatf("stream%0d_in_ready", i), 32'(in_ready), 32'd1);
      check($sformatf("stream%0d_rw", i), 32'(out_reg_write), 32'd1);
    end
    in_valid = 1'b0;
    cyc();
    check("drain_valid", 32'(out_valid), 32'd0);
    check("drain_rw", 32'(out_reg_write), 32'd0);

    // Divide hold: cycles 1-4 blocked, valid at cycle 5, follow-on accepted then.
    drive(SelDiv, 32'h200, 32'd100, 32'd7, 32'h0, 1'b0, 1'b0, 5'd9, 5'd0, 5'd0);
    cyc();
    drive(SelAdd, 32'h204, 32'h55, 32'h1, 32'h0, 1'b0, 1'b0, 5'd10, 5'd0, 5'd0);
    for (int k = 1; k <= 4; k++) begin
      check($sformatf("div_c%0d_valid", k), 32'(out_valid), 32'd0);
      check($sformatf("div_c%0d_in_ready", k), 32'(in_ready), 32'd0);
      check($sformatf("div_c%0d_rw", k), 32'(out_reg_write), 32'd0);
      check($sformatf("div_c%0d_sel", k), 32'(alu_select), 32'(SelDiv));
      cyc();
    end
    check("div_c5_valid", 32'(out_valid), 32'd1);
    check("div_c5_data1", alu_data1, 32'd100);
    check("div_c5_data2", alu_data2, 32'd7);
    check("div_c5_in_ready", 32'(in_ready), 32'd1);
    check("div_c5_rw", 32'(out_reg_write), 32'd1);
    cyc();
    check("div_next_valid", 32'(out_valid), 32'd1);
    check("div_next_data1", alu_data1, 32'h55);

    // Downstream stall.
    drive(SelAdd, 32'h208, 32'h77, 32'h2, 32'h0, 1'b0, 1'b0, 5'd11, 5'd0, 5'd0);
    out_ready = 1'b0;
    for (int k = 0; k < 3; k++) begin
      #1;
      check($sformatf("stall%0d_valid", k), 32'(out_valid), 32'd1);
      check($sformatf("stall%0d_data1", k), alu_data1, 32'h55);
      check($sformatf("stall%0d_in_ready", k), 32'(in_ready), 32'd0);
      cyc();
    end
    out_ready = 1'b1;
    #1;
    check("stall_release_in_ready", 32'(in_ready), 32'd1);
    cyc();
    check("stall_resume_data1", alu_data1, 32'h77);
    check("stall_resume_rd", 32'(out_rd_addr), 32'd11);

    // Flush squashes held and incoming ops, leaves held fields alone.
    drive(SelAdd, 32'h20C, 32'h99, 32'h3, 32'h0, 1'b0, 1'b0, 5'd12, 5'd0, 5'd0);
    flush = 1'b1;
    cyc();
    flush = 1'b0;
    in_valid = 1'b0;
    #1;
    check("flush_valid", 32'(out_valid), 32'd0);
    check("flush_data1", alu_data1, 32'h77);
    check("flush_rd", 32'(out_rd_addr), 32'd11);
    check("flush_in_ready", 32'(in_ready), 32'd1);

`ifdef ID_EX_FORWARD_EN
    drive(SelAdd, 32'h300, 32'hDEAD, 32'h1, 32'h0, 1'b0, 1'b0, 5'd7, 5'd5, 5'd6);
    out_ready = 1'b0;
    cyc();
    in_valid = 1'b0;
    exmem_reg_write = 1'b1; exmem_rd_addr = 5'd5; exmem_result = 32'h11;
    memwb_reg_write = 1'b1; memwb_rd_addr = 5'd5; memwb_result = 32'h22;
    #1;
    check("fwd_exmem_wins", alu_data1, 32'h11);
    exmem_reg_write = 1'b0;
    #1;
    check("fwd_memwb", alu_data1, 32'h22);
    memwb_rd_addr = 5'd6; memwb_result = 32'hAB;
    cyc();
    memwb_reg_write = 1'b0;
    cyc();
    check("fwd_retired_data2", alu_data2, 32'hAB);
    check("fwd_retired_rs2", out_rs2_data, 32'hAB);
    check("fwd_retired_data1", alu_data1, 32'hDEAD);
    out_ready = 1'b1;
    cyc();
    drive(SelAdd, 32'h304, 32'h0, 32'h0, 32'h0, 1'b0, 1'b0, 5'd8, 5'd0, 5'd0);
    cyc();
    in_valid = 1'b0;
    exmem_reg_write = 1'b1; exmem_rd_addr = 5'd0; exmem_result = 32'h33;
    memwb_reg_write = 1'b1; memwb_rd_addr = 5'd0; memwb_result = 32'h44;
    #1;
    check("fwd_x0_none", alu_data1, 32'h0);
    exmem_reg_write = 1'b0; memwb_reg_write = 1'b0;
    cyc();
`endif

    // Asynchronous reset during a divide hold with counter at 2.
    drive(SelDiv, 32'h400, 32'h1234, 32'h5, 32'h0, 1'b0, 1'b0, 5'd13, 5'd0, 5'd0);
    cyc();
    in_valid = 1'b0;
    cyc();
    cyc();
    check("pre_reset_valid", 32'(out_valid), 32'd0);
    check("pre_reset_data1", alu_data1, 32'h1234);
    rst_n = 1'b0;
    #1;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_in_ready", 32'(in_ready), 32'd0);
    check("rst_data1", alu_data1, 32'h0);
    check("rst_data2", alu_data2, 32'h0);
    check("rst_sel", 32'(alu_select), 32'h0);
    check("rst_pc", out_pc, 32'h0);
    check("rst_rd", 32'(out_rd_addr), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    check("rst_release_in_ready", 32'(in_ready), 32'd1);
    check("rst_release_valid", 32'(out_valid), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
